// File: rtl/kirby_scene_pkg.sv
// -----------------------------------------------------------------------------
// kirby_scene_pkg
// Shared types and constants for the Kirby scene controller:
//   scene_state_t  - top-level scene FSM states
//   kirby_state_t  - encodings driven on Kirby_state (NORMAL/INHOLE/DAMAGE)
//   MAP_LAST       - index of the final area map
//   START_KEY_DEFAULT - default keycode that leaves the title screen
//   cnt_width()    - counter width helper (never narrower than one bit)
// -----------------------------------------------------------------------------
package kirby_scene_pkg;

  typedef enum logic [2:0] {
    S_TITLE      = 3'd0,
    S_PLAY       = 3'd1,
    S_TRANSITION = 3'd2,
    S_WIN        = 3'd3,
    S_GAME_OVER  = 3'd4
  } scene_state_t;

  typedef enum logic [1:0] {
    K_NORMAL = 2'd0,
    K_INHOLE = 2'd1,
    K_DAMAGE = 2'd2
  } kirby_state_t;

  localparam logic [1:0] MAP_LAST          = 2'd2;
  localparam logic [7:0] START_KEY_DEFAULT = 8'h28;
  localparam logic [1:0] LIVES_INIT        = 2'd3;

  // Width of a down-counter whose largest loaded value is max_val-1.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/kirby_scene_ctrl_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Brings the VGA frame strobe into the Clk domain through two flops and emits
// a one-Clk pulse on every rising edge of the synchronised strobe.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset (clears all three flops)
//   frame_clk  - frame strobe, asynchronous to clk
//   frame_tick - single-cycle pulse per frame
// -----------------------------------------------------------------------------
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-flop synchroniser followed by a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= frame_clk;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // All flops clear on reset, so no pulse can appear right after release.
  assign frame_tick = sync2_r & ~prev_r;

endmodule

// File: rtl/kirby_scene_ctrl.sv
// -----------------------------------------------------------------------------
// kirby_scene_ctrl
// Scene sequencer for the Kirby game: title screen, play across three maps,
// map transitions, damage/lives handling, the star reward and win/game-over
// holds. All decisions are taken on a frame tick and appear one Clk later.
// Ports:
//   Clk, Reset      - system clock, synchronous active-high reset
//   frame_clk       - VGA frame strobe (asynchronous)
//   keycode         - current keyboard keycode
//   kirby_hit, kirby_at_door, kirby_in_hole, boss_defeated, star_collected
//                   - game-logic event levels, sampled on frame ticks only
//   Gamestart       - 0 title screen, 1 in-game layers
//   Map_idx         - active map 0..2
//   Kirby_state     - 0 normal, 1 in hole, 2 damage
//   Star_appear     - star layer enable
//   Lives           - remaining lives
// Build option: define STAR_BLINK_EN to blink the armed star every 8 ticks.
// -----------------------------------------------------------------------------
module kirby_scene_ctrl
  import kirby_scene_pkg::*;
#(
  parameter int         DAMAGE_FRAMES     = 60,
  parameter int         TRANSITION_FRAMES = 30,
  parameter logic [7:0] START_KEY         = START_KEY_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       kirby_hit,
  input  logic       kirby_at_door,
  input  logic       kirby_in_hole,
  input  logic       boss_defeated,
  input  logic       star_collected,
  output logic       Gamestart,
  output logic [1:0] Map_idx,
  output logic [1:0] Kirby_state,
  output logic       Star_appear,
  output logic [1:0] Lives
);

  localparam int DW = cnt_width(DAMAGE_FRAMES);
  localparam int TW = cnt_width(TRANSITION_FRAMES);
  localparam logic [DW-1:0] DMG_LOAD = DW'(DAMAGE_FRAMES - 1);
  localparam logic [DW-1:0] DMG_ONE  = DW'(1);
  localparam logic [TW-1:0] TR_LOAD  = TW'(TRANSITION_FRAMES - 1);
  localparam logic [TW-1:0] TR_ONE   = TW'(1);

  logic          frame_tick;
  scene_state_t  scene_r;
  logic [TW-1:0] frame_cnt_r;
  logic [DW-1:0] dmg_cnt_r;
  logic          star_armed_r;
  logic          blink_flip;

  logic          hit_ev;
  logic          star_ev;
  logic          door_ev;
  logic          boss_ev;
  logic [1:0]    hole_state;

  frame_tick_gen u_tick (
    .clk        (Clk),
    .reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Events that would actually take effect; ignored events never mask
  // lower-priority ones.
  assign hit_ev     = kirby_hit & (Kirby_state != K_DAMAGE);
  assign star_ev    = star_collected & star_armed_r;
  assign door_ev    = kirby_at_door & (Map_idx < MAP_LAST);
  assign boss_ev    = boss_defeated & (Map_idx == MAP_LAST) & ~star_armed_r;
  assign hole_state = kirby_in_hole ? K_INHOLE : K_NORMAL;

`ifdef STAR_BLINK_EN
  logic [2:0] blink_cnt_r;

  // Counts play ticks while the star is armed; flips the star every 8th.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt_r <= 3'd0;
    end else if (frame_tick && (scene_r == S_PLAY) && star_armed_r) begin
      blink_cnt_r <= blink_cnt_r + 3'd1;
    end else if (!star_armed_r) begin
      blink_cnt_r <= 3'd0;
    end
  end

  assign blink_flip = (blink_cnt_r == 3'd7);
`else
  assign blink_flip = 1'b0;
`endif

  // Scene FSM with the Kirby sub-FSM folded into PLAY; all outputs registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scene_r      <= S_TITLE;
      frame_cnt_r  <= '0;
      dmg_cnt_r    <= '0;
      star_armed_r <= 1'b0;
      Gamestart    <= 1'b0;
      Map_idx      <= 2'd0;
      Kirby_state  <= K_NORMAL;
      Star_appear  <= 1'b0;
      Lives        <= LIVES_INIT;
    end else if (frame_tick) begin
      case (scene_r)
        S_TITLE: begin
          if (keycode == START_KEY) begin
            scene_r   <= S_PLAY;
            Gamestart <= 1'b1;
          end
        end

        S_PLAY: begin
          // Baseline Kirby update; a hit below overrides it.
          if (Kirby_state == K_DAMAGE) begin
            if (dmg_cnt_r == '0) begin
              Kirby_state <= hole_state;
            end else begin
              dmg_cnt_r <= dmg_cnt_r - DMG_ONE;
            end
          end else begin
            Kirby_state <= hole_state;
          end

          if (star_armed_r && blink_flip) begin
            Star_appear <= ~Star_appear;
          end

          if (hit_ev) begin
            Kirby_state <= K_DAMAGE;
            dmg_cnt_r   <= DMG_LOAD;
            if (Lives == 2'd1) begin
              Lives        <= 2'd0;
              scene_r      <= S_GAME_OVER;
              frame_cnt_r  <= TR_LOAD;
              star_armed_r <= 1'b0;
              Star_appear  <= 1'b0;
            end else begin
              Lives <= Lives - 2'd1;
            end
          end else if (star_ev) begin
            scene_r      <= S_WIN;
            frame_cnt_r  <= TR_LOAD;
            star_armed_r <= 1'b0;
            Star_appear  <= 1'b0;
          end else if (door_ev) begin
            scene_r     <= S_TRANSITION;
            frame_cnt_r <= TR_LOAD;
            Kirby_state <= K_NORMAL;
            dmg_cnt_r   <= '0;
          end else if (boss_ev) begin
            star_armed_r <= 1'b1;
            Star_appear  <= 1'b1;
          end
        end

        S_TRANSITION: begin
          Kirby_state <= K_NORMAL;
          if (frame_cnt_r == '0) begin
            scene_r <= S_PLAY;
            if (Map_idx < MAP_LAST) begin
              Map_idx <= Map_idx + 2'd1;
            end
          end else begin
            frame_cnt_r <= frame_cnt_r - TR_ONE;
          end
        end

        S_WIN, S_GAME_OVER: begin
          if (frame_cnt_r == '0) begin
            scene_r      <= S_TITLE;
            dmg_cnt_r    <= '0;
            star_armed_r <= 1'b0;
            Gamestart    <= 1'b0;
            Map_idx      <= 2'd0;
            Kirby_state  <= K_NORMAL;
            Star_appear  <= 1'b0;
            Lives        <= LIVES_INIT;
          end else begin
            frame_cnt_r <= frame_cnt_r - TR_ONE;
          end
        end

        default: begin
          scene_r <= S_TITLE;
        end
      endcase
    end
  end

endmodule

// File: doc/kirby_scene_ctrl.md
KIRBY_SCENE_CTRL -- requirements
Module: kirby_scene_ctrl

Interface
REQ-001 SHALL have parameter DAMAGE_FRAMES, default 60, frames Kirby stays in damage state after a hit.
REQ-002 SHALL have parameter TRANSITION_FRAMES, default 30, frames spent in map-transition, win and game-over holds.
REQ-003 SHALL have parameter START_KEY, default 8'h28, keycode that starts the game.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 SHALL have port Clk, input, 1, system clock.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port frame_clk, input, 1, VGA vertical-sync frame strobe, asynchronous to Clk.
REQ-008 SHALL have port keycode, input, 8, current keyboard keycode.
REQ-009 SHALL have ports kirby_hit, kirby_at_door, kirby_in_hole, boss_defeated and star_collected, each input, 1, game-logic event levels.
REQ-010 SHALL have port Gamestart, output, 1, 0 = title screen, 1 = in-game layers.
REQ-011 SHALL have port Map_idx, output, 2, active area map 0..2.
REQ-012 SHALL have port Kirby_state, output, 2, 0 = normal, 1 = in-hole, 2 = damage.
REQ-013 SHALL have port Star_appear, output, 1, enables the star layer.
REQ-014 SHALL have port Lives, output, 2, remaining lives.

Function
REQ-015 SHALL synchronise frame_clk through two flops and generate frame_tick, a single-Clk pulse on each rising edge.
REQ-016 SHALL sample all event inputs and keycode only in a cycle where frame_tick=1.
REQ-017 SHALL register all outputs; a change decided on a tick SHALL appear one Clk cycle later.
REQ-018 SHALL implement the scene FSM states TITLE, PLAY, TRANSITION, WIN and GAME_OVER.
REQ-019 In TITLE: Gamestart=0, Map_idx=0, Kirby_state=0, Star_appear=0 and Lives=3; keycode==START_KEY on a tick SHALL go to PLAY.
REQ-020 In PLAY, kirby_at_door on a tick with Map_idx<2 SHALL go to TRANSITION and load the frame counter with TRANSITION_FRAMES-1.
REQ-021 In PLAY with Map_idx==2, kirby_at_door SHALL be ignored.
REQ-022 In TRANSITION, Kirby_state SHALL be forced to 0 and hits SHALL be ignored.
REQ-023 In TRANSITION, the counter SHALL decrement per tick; on the tick with counter==0, Map_idx SHALL increment by 1 and the FSM SHALL return to PLAY.
REQ-024 Map_idx SHALL never exceed 2 and SHALL never wrap.
REQ-025 boss_defeated on a tick in PLAY with Map_idx==2 SHALL set Star_appear; Star_appear SHALL stay set until the FSM leaves PLAY.
REQ-026 star_collected on a tick while Star_appear=1 SHALL go to WIN; star_collected while Star_appear=0 SHALL be ignored.
REQ-027 WIN and GAME_OVER SHALL hold TRANSITION_FRAMES ticks with Gamestart=1, then go to TITLE, restoring all TITLE values.
REQ-028 The Kirby sub-FSM SHALL be active only in PLAY.
REQ-029 kirby_hit on a tick with Kirby_state!=2 SHALL set Kirby_state=2, load the damage counter with DAMAGE_FRAMES-1 and decrement Lives.
REQ-030 If Lives was 1 at the hit, the scene FSM SHALL go to GAME_OVER with Lives=0.
REQ-031 kirby_hit while Kirby_state==2 SHALL be ignored (invulnerable).
REQ-032 When the damage counter expires, Kirby_state SHALL become 1 if kirby_in_hole=1, else 0.
REQ-033 Outside damage, Kirby_state SHALL follow kirby_in_hole (1/0) on each tick.
REQ-034 Simultaneous events on one tick SHALL be resolved with priority kirby_hit > star_collected > kirby_at_door > boss_defeated; lower-priority events on that tick SHALL be dropped.
REQ-035 Kirby_state SHALL never be 3.
REQ-036 Counters SHALL be sized $clog2 of their max parameter and SHALL saturate at 0.

Reset
REQ-037 Reset=1 at a rising Clk edge SHALL, from any state including mid-transition or mid-damage, enter TITLE with Gamestart=0, Map_idx=0, Kirby_state=0, Star_appear=0, Lives=3, counters=0 and synchroniser flops=0.
REQ-038 No frame_tick SHALL be generated in the cycle following reset release.

Configuration
REQ-039 With STAR_BLINK_EN defined, Star_appear, once set, SHALL toggle every 8 ticks, starting high.
REQ-040 Without STAR_BLINK_EN, Star_appear SHALL be a steady 1.
REQ-041 star_collected SHALL be accepted whenever the star is armed, regardless of blink phase.

Structure
REQ-042 Package kirby_scene_pkg SHALL hold the scene_state_t enum, kirby_state_t encodings (NORMAL=0, INHOLE=1, DAMAGE=2), the MAP_LAST=2 constant and the default START_KEY.
REQ-043 The single sub-module SHALL be frame_tick_gen, containing the synchroniser and edge detector.

Verification
REQ-044 Reset, then keycode=8'h28 for 1 frame -> Gamestart=1 one Clk after that tick, with Map_idx=0 and Lives=3.
REQ-045 In PLAY, kirby_at_door=1 at Map_idx=0 with TRANSITION_FRAMES=4 -> Map_idx=1 after exactly 4 ticks and Kirby_state=0 throughout.
REQ-046 Three kirby_hit pulses spaced 70 frames apart -> Lives 2, 1, then GAME_OVER; TITLE after 30 more ticks.
REQ-047 Hits on frames 0 and 10 -> only one decrement; Kirby_state=2 for 60 ticks, then 1 if kirby_in_hole=1 at expiry.
REQ-048 At Map_idx=2, boss_defeated then star_collected -> Star_appear=1, then WIN, then TITLE; with STAR_BLINK_EN, Star_appear toggles every 8 ticks while armed.
REQ-049 Reset asserted mid-TRANSITION at counter=2 -> next cycle Gamestart=0 and Map_idx=0; kirby_hit together with kirby_at_door on one tick -> damage taken and no transition.
